// File: rtl/enable_generator_pkg.sv
// Shared definitions for the multichannel enable generator: control FSM
// state encoding and default sizing constants.
package enable_generator_pkg;

  localparam int unsigned DEFAULT_COUNTER_WIDTH = 32;
  localparam int unsigned DEFAULT_N_CHANNELS    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : enable_generator_pkg

// File: rtl/enable_channel_comparator.sv
// One compare channel: double-buffered compare value plus a registered,
// single-cycle match pulse against the shared period counter.
module enable_channel_comparator
  import enable_generator_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_run_i,
  input  logic                     tick_i,
  input  logic                     wrap_i,
  input  logic [COUNTER_WIDTH-1:0] counter_i,
  input  logic [COUNTER_WIDTH-1:0] compare_i,
  output logic                     enable_o
);

  logic [COUNTER_WIDTH-1:0] compare_s_q, compare_s_d;
  logic                     enable_q, enable_d;
  logic                     load;

  // Shadow follows the input while stopped; while running it only updates on
  // the wrap, so a mid-period write takes effect from the next period.
  assign load = !in_run_i || wrap_i;

  // Next shadow value and match pulse; a compare at or above the period is
  // never reached by the counter and so never fires.
  always_comb begin
    compare_s_d = compare_s_q;
    if (load) begin
      compare_s_d = compare_i;
    end
    enable_d = in_run_i && tick_i && (counter_i == compare_s_q);
  end

  // Shadow compare and pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      compare_s_q <= '0;
      enable_q    <= 1'b0;
    end else begin
      compare_s_q <= compare_s_d;
      enable_q    <= enable_d;
    end
  end

  assign enable_o = enable_q;

endmodule : enable_channel_comparator

// File: rtl/enable_generator_multichannel.sv
// Multichannel enable generator: one shared period counter with a control
// FSM (IDLE/RUN/DONE), a double-buffered period, and N compare channels that
// each emit a one-cycle enable pulse at their own phase in the period.
module enable_generator_multichannel
  import enable_generator_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH            = DEFAULT_COUNTER_WIDTH,
  parameter int unsigned N_CHANNELS               = DEFAULT_N_CHANNELS,
  parameter int unsigned EXTERNAL_TIMEBASE_ENABLE = 0
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                external_timebase,
  input  logic                                gen_enable_in,
  input  logic                                one_shot,
  input  logic [COUNTER_WIDTH-1:0]            period,
  input  logic [N_CHANNELS*COUNTER_WIDTH-1:0] compare,
  output logic [N_CHANNELS-1:0]               enable_out,
  output logic [COUNTER_WIDTH-1:0]            counter_out,
  output logic                                period_done,
  output logic                                busy
);

  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
  logic [COUNTER_WIDTH-1:0] period_s_q, period_s_d;
  logic                     period_done_q, period_done_d;

  logic                     tick;
  logic                     in_run;
  logic                     period_nz;
  logic                     wrap;
  logic                     shadow_load;

  assign tick        = (EXTERNAL_TIMEBASE_ENABLE != 0) ? external_timebase : 1'b1;
  assign in_run      = (state_q == ST_RUN);
  assign period_nz   = (period_s_q != '0);
  assign wrap        = in_run && tick && period_nz &&
                       (counter_q == period_s_q - COUNTER_WIDTH'(1));
  assign shadow_load = !in_run || wrap;

  // Next-state, counter and period shadow. Disable has priority over the
  // wrap, but period_done still reports a wrap reached on that cycle.
  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    period_s_d    = period_s_q;
    period_done_d = wrap;
    if (shadow_load) begin
      period_s_d = period;
    end
    unique case (state_q)
      ST_IDLE: begin
        counter_d = '0;
        if (gen_enable_in && period_nz) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!gen_enable_in) begin
          state_d   = ST_IDLE;
          counter_d = '0;
        end else if (!period_nz) begin
          // Period input dropped to zero on the start cycle: nothing to count.
          state_d   = ST_IDLE;
          counter_d = '0;
        end else if (wrap) begin
          counter_d = '0;
          if (one_shot) begin
            state_d = ST_DONE;
          end else if (period == '0) begin
            state_d = ST_IDLE;
          end
        end else if (tick) begin
          counter_d = counter_q + COUNTER_WIDTH'(1);
        end
      end
      ST_DONE: begin
        counter_d = '0;
        if (!gen_enable_in) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        counter_d = '0;
      end
    endcase
  end

  // FSM, counter, period shadow and period_done registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      counter_q     <= '0;
      period_s_q    <= '0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      period_s_q    <= period_s_d;
      period_done_q <= period_done_d;
    end
  end

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_chan
    enable_channel_comparator #(
      .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_chan (
      .clk_i    (clock),
      .rst_ni   (reset),
      .in_run_i (in_run),
      .tick_i   (tick),
      .wrap_i   (wrap),
      .counter_i(counter_q),
      .compare_i(compare[i*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .enable_o (enable_out[i])
    );
  end

  assign counter_out = counter_q;
  assign period_done = period_done_q;
  assign busy        = in_run;

endmodule : enable_generator_multichannel

// File: tb/tb_enable_generator_multichannel.sv
// Testbench for enable_generator_multichannel: per-cycle vector table on an
// internal-tick instance, plus directed sequences for shadow reload, external
// timebase and asynchronous reset.
module tb_enable_generator_multichannel;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic           clock;
  logic           reset;
  logic           ext_tick;
  logic           gen_en;
  logic           one_shot;
  logic [W-1:0]   period;
  logic [N*W-1:0] compare;

  logic [N-1:0]   en_int,  en_ext;
  logic [W-1:0]   cnt_int, cnt_ext;
  logic           pd_int,  pd_ext;
  logic           bz_int,  bz_ext;

  int n_checks = 0;
  int n_fail   = 0;

  enable_generator_multichannel #(
    .COUNTER_WIDTH(W),
    .N_CHANNELS(N),
    .EXTERNAL_TIMEBASE_ENABLE(0)
  ) dut_int (
    .clock(clock), .reset(reset), .external_timebase(ext_tick),
    .gen_enable_in(gen_en), .one_shot(one_shot), .period(period),
    .compare(compare), .enable_out(en_int), .counter_out(cnt_int),
    .period_done(pd_int), .busy(bz_int)
  );

  enable_generator_multichannel #(
    .COUNTER_WIDTH(W),
    .N_CHANNELS(N),
    .EXTERNAL_TIMEBASE_ENABLE(1)
  ) dut_ext (
    .clock(clock), .reset(reset), .external_timebase(ext_tick),
    .gen_enable_in(gen_en), .one_shot(one_shot), .period(period),
    .compare(compare), .enable_out(en_ext), .counter_out(cnt_ext),
    .period_done(pd_ext), .busy(bz_ext)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic           gen;
    logic           os;
    logic [W-1:0]   per;
    logic [N*W-1:0] cmp;
    logic [N-1:0]   en;
    logic [W-1:0]   cnt;
    logic           pd;
    logic           bz;
  } vec_t;

  vec_t vecs[$];

  // Compare sets, packed {ch3, ch2, ch1, ch0}.
  localparam logic [N*W-1:0] CMP_A = {8'd7, 8'd4,   8'd2, 8'd0};
  localparam logic [N*W-1:0] CMP_B = {8'd4, 8'd200, 8'd9, 8'd3};
  localparam logic [N*W-1:0] CMP_C = {8'd1, 8'd5,   8'd0, 8'd0};
  localparam logic [N*W-1:0] CMP_D = {8'd9, 8'd3,   8'd0, 8'd1};

  task automatic add(input logic g, input logic os, input logic [W-1:0] p,
                     input logic [N*W-1:0] c, input logic [N-1:0] e,
                     input logic [W-1:0] cn, input logic pd, input logic bz);
    vec_t v;
    v.gen = g; v.os = os; v.per = p; v.cmp = c;
    v.en = e; v.cnt = cn; v.pd = pd; v.bz = bz;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  int unsigned k;
  logic [W-1:0] exp_cnt3 [12] = '{8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0};
  logic         exp_en3  [12] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0};
  logic         exp_pd3  [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1};

  initial begin
    reset = 1'b0; ext_tick = 1'b0; gen_en = 1'b0; one_shot = 1'b0;
    period = '0; compare = '0;

    // Reset state
    repeat (2) step();
    check("reset en_int",  32'(en_int),  32'h0);
    check("reset cnt_int", 32'(cnt_int), 32'h0);
    check("reset pd_int",  32'(pd_int),  32'h0);
    check("reset bz_int",  32'(bz_int),  32'h0);
    check("reset bz_ext",  32'(bz_ext),  32'h0);
    reset = 1'b1;

    // Continuous run, period 5, compares {0,2,4,7}
    add(0,0,5,CMP_A, 4'b0000,0,0,0);
    add(1,0,5,CMP_A, 4'b0000,0,0,1);
    add(1,0,5,CMP_A, 4'b0001,1,0,1);
    add(1,0,5,CMP_A, 4'b0000,2,0,1);
    add(1,0,5,CMP_A, 4'b0010,3,0,1);
    add(1,0,5,CMP_A, 4'b0000,4,0,1);
    add(1,0,5,CMP_A, 4'b0100,0,1,1);
    add(1,0,5,CMP_A, 4'b0001,1,0,1);
    add(1,0,5,CMP_A, 4'b0000,2,0,1);
    add(1,0,5,CMP_A, 4'b0010,3,0,1);
    add(1,0,5,CMP_A, 4'b0000,4,0,1);
    add(1,0,5,CMP_A, 4'b0100,0,1,1);
    add(1,0,5,CMP_A, 4'b0001,1,0,1);
    add(0,0,5,CMP_A, 4'b0000,0,0,0);
    // One-shot, period 4, compare[0]=3, compare[3]=period (never fires)
    add(0,1,4,CMP_B, 4'b0000,0,0,0);
    add(1,1,4,CMP_B, 4'b0000,0,0,1);
    add(1,1,4,CMP_B, 4'b0000,1,0,1);
    add(1,1,4,CMP_B, 4'b0000,2,0,1);
    add(1,1,4,CMP_B, 4'b0000,3,0,1);
    add(1,1,4,CMP_B, 4'b0001,0,1,0);
    add(1,1,4,CMP_B, 4'b0000,0,0,0);
    add(1,1,4,CMP_B, 4'b0000,0,0,0);
    add(0,1,4,CMP_B, 4'b0000,0,0,0);
    add(1,1,4,CMP_B, 4'b0000,0,0,1);
    add(1,1,4,CMP_B, 4'b0000,1,0,1);
    add(1,1,4,CMP_B, 4'b0000,2,0,1);
    add(1,1,4,CMP_B, 4'b0000,3,0,1);
    add(1,1,4,CMP_B, 4'b0001,0,1,0);
    add(0,1,4,CMP_B, 4'b0000,0,0,0);
    // Period 0 stays idle
    add(0,0,0,CMP_B, 4'b0000,0,0,0);
    add(1,0,0,CMP_B, 4'b0000,0,0,0);
    add(1,0,0,CMP_B, 4'b0000,0,0,0);
    add(1,0,0,CMP_B, 4'b0000,0,0,0);
    // Period 1: wrap every tick, two channels at compare 0 fire together
    add(1,0,1,CMP_C, 4'b0000,0,0,0);
    add(1,0,1,CMP_C, 4'b0000,0,0,1);
    add(1,0,1,CMP_C, 4'b0011,0,1,1);
    add(1,0,1,CMP_C, 4'b0011,0,1,1);
    add(1,0,1,CMP_C, 4'b0011,0,1,1);
    // Reload to period 3 at wrap, then disable on the wrap cycle
    add(1,0,3,CMP_D, 4'b0011,0,1,1);
    add(1,0,3,CMP_D, 4'b0010,1,0,1);
    add(1,0,3,CMP_D, 4'b0001,2,0,1);
    add(0,0,3,CMP_D, 4'b0000,0,1,0);
    add(0,0,3,CMP_D, 4'b0000,0,0,0);

    foreach (vecs[i]) begin
      gen_en   = vecs[i].gen;
      one_shot = vecs[i].os;
      period   = vecs[i].per;
      compare  = vecs[i].cmp;
      step();
      check($sformatf("row%0d enable_out",  i), 32'(en_int),  32'(vecs[i].en));
      check($sformatf("row%0d counter_out", i), 32'(cnt_int), 32'(vecs[i].cnt));
      check($sformatf("row%0d period_done", i), 32'(pd_int),  32'(vecs[i].pd));
      check($sformatf("row%0d busy",        i), 32'(bz_int),  32'(vecs[i].bz));
    end

    // Shadow reload: period 8 -> 3 and compare[1] 5 -> 1 mid-period
    one_shot = 1'b0; period = 8'd8; compare = {8'd200, 8'd200, 8'd5, 8'd200};
    gen_en = 1'b0; step();
    gen_en = 1'b1; step();
    check("reload start busy", 32'(bz_int),  32'h1);
    check("reload start cnt",  32'(cnt_int), 32'h0);
    step(); step();
    check("reload mid cnt",    32'(cnt_int), 32'h2);
    period = 8'd3; compare = {8'd200, 8'd200, 8'd1, 8'd200};
    for (int j = 0; j < 12; j++) begin
      step();
      check($sformatf("reload%0d cnt", j), 32'(cnt_int), 32'(exp_cnt3[j]));
      check($sformatf("reload%0d en",  j), 32'(en_int),  32'({2'b00, exp_en3[j], 1'b0}));
      check($sformatf("reload%0d pd",  j), 32'(pd_int),  32'(exp_pd3[j]));
    end
    gen_en = 1'b0; step();

    // External timebase: tick every third clock, period 4, compare[0]=1
    period = 8'd4; compare = {8'd200, 8'd200, 8'd200, 8'd1};
    ext_tick = 1'b0; gen_en = 1'b0; step();
    gen_en = 1'b1; step();
    check("ext start busy", 32'(bz_ext),  32'h1);
    check("ext start cnt",  32'(cnt_ext), 32'h0);
    for (k = 1; k <= 24; k++) begin
      ext_tick = (k % 3 == 0);
      step();
      check($sformatf("ext%0d cnt", k), 32'(cnt_ext), (k / 3) % 4);
      check($sformatf("ext%0d en",  k), 32'(en_ext),  (k % 12 == 6)  ? 32'h1 : 32'h0);
      check($sformatf("ext%0d pd",  k), 32'(pd_ext),  (k % 12 == 0)  ? 32'h1 : 32'h0);
    end
    ext_tick = 1'b0; gen_en = 1'b0; step();

    // Asynchronous reset mid-run, between clock edges
    period = 8'd5; compare = CMP_A; step();
    gen_en = 1'b1; step(); step();
    check("prereset en",  32'(en_int),  32'h1);
    check("prereset cnt", 32'(cnt_int), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("async en",   32'(en_int),  32'h0);
    check("async cnt",  32'(cnt_int), 32'h0);
    check("async busy", 32'(bz_int),  32'h0);
    check("async pd",   32'(pd_int),  32'h0);
    #2 reset = 1'b1;
    step();
    check("post idle busy", 32'(bz_int),  32'h0);
    step();
    check("post run busy",  32'(bz_int),  32'h1);
    check("post run cnt",   32'(cnt_int), 32'h0);
    step();
    check("post cnt1",      32'(cnt_int), 32'h1);
    check("post en0",       32'(en_int),  32'h1);
    gen_en = 1'b0; step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_enable_generator_multichannel

// File: doc/enable_generator_multichannel.md
Name: enable_generator_multichannel

Overview:
Parametrised successor to the single-channel enable counter. One shared free-running period counter drives N_CHANNELS independent compare channels. Each channel emits a one-cycle enable pulse at its own phase within the period. Adds double-buffered compares, a one-shot mode, a period-done strobe and a small control FSM. Sits in the system block between the control register file and the PWM/ADC trigger consumers.

Parameters:
- COUNTER_WIDTH, 32: width of the counter, period and each compare value.
- N_CHANNELS, 4: number of compare/enable channels (≥1).
- EXTERNAL_TIMEBASE_ENABLE, 0: 1 = counter advances only on cycles with external_timebase=1; 0 = advances every clock.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- external_timebase  in  1  count qualifier; used only when EXTERNAL_TIMEBASE_ENABLE=1
- gen_enable_in  in  1  run request, level sensitive
- one_shot  in  1  1 = single period then stop; 0 = continuous
- period  in  COUNTER_WIDTH  period in ticks
- compare  in  N_CHANNELS*COUNTER_WIDTH  per-channel phase; channel i is in bits [i*W +: W]
- enable_out  out  N_CHANNELS  per-channel one-cycle enable pulses
- counter_out  out  COUNTER_WIDTH  current counter value
- period_done  out  1  one-cycle strobe at the end of each period
- busy  out  1  1 while FSM is in RUN

Behaviour:
- Reset (asynchronous, active-low) forces:
  - FSM = IDLE
  - counter, period_s, compare_s[*] = 0
  - enable_out, period_done, busy = 0
- tick = external_timebase when EXTERNAL_TIMEBASE_ENABLE=1, else constant 1.
- Shadow registers period_s and compare_s[i]:
  - Load from the inputs every cycle in IDLE and DONE.
  - In RUN, load only on the wrap cycle (tick & counter == period_s-1).
  - Mid-period input changes have no effect until the next wrap.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when gen_enable_in=1 and period_s≠0. Counter starts at 0 and busy=1 from the next cycle.
  - RUN on tick:
    - counter == period_s-1: counter ← 0, period_done=1 next cycle.
    - If one_shot=1, go to DONE.
    - If one_shot=0 and the newly loaded period is 0, go to IDLE.
    - Otherwise counter ← counter+1.
  - RUN with tick=0: counter holds.
  - DONE: counter = 0, busy = 0, no pulses. DONE → IDLE when gen_enable_in=0.
  - Any state with gen_enable_in=0 → IDLE on the next clock. Counter clears to 0; enable_out and period_done are 0 from that cycle on.
- Channel pulse: enable_out[i] is registered and set to (state==RUN & tick & counter==compare_s[i]).
  - Latency is 1 clock after counter_out shows the matching value.
  - Pulse width is exactly 1 clock, even when the external tick is held high.
  - compare_s[i] ≥ period_s: channel never fires.
  - Multiple channels with equal compares fire in the same cycle.
- period_done is registered: 1 clock after the wrap-cycle counter value.
- Period of 1: counter stays at 0. Every tick produces a wrap, period_done, and a pulse on compare==0 channels.
- Arithmetic: counter is unsigned COUNTER_WIDTH and never exceeds period_s-1, so no overflow. The period_s-1 comparison is evaluated only when period_s≠0.
- Simultaneous wrap and gen_enable_in falling: disable wins (IDLE). period_done still pulses, since the wrap was reached.

Decomposition:
- Package enable_generator_pkg holds:
  - FSM state typedef (IDLE, RUN, DONE)
  - default width and channel-count constants
- Sub-module enable_channel_comparator, instanced N_CHANNELS times in a generate loop. It contains:
  - the compare shadow register
  - the shadow-load qualifier
  - the registered match pulse
- The top holds the FSM, counter, period shadow and tick selection.

Test Plan:
1. Continuous run, internal tick: period=5, compares {0,2,4,7}, gen_enable_in=1.
   - enable_out[0] pulses every 5 clocks; [1] 2 clocks later; [2] 4 clocks later; [3] never.
   - period_done aligns with [2]'s pulse.
2. One-shot: period=4, one_shot=1, compare[0]=3.
   - Exactly one enable_out[0] pulse and one period_done.
   - busy high 4 clocks then DONE.
   - Re-run requires gen_enable_in 1→0→1.
3. Shadow reload: mid-period, change period 8→3 and compare[1] 5→1.
   - The current period completes 8 counts with a pulse at 5.
   - Subsequent periods are 3 counts with the pulse at 1.
4. External timebase (EXTERNAL_TIMEBASE_ENABLE=1): tick every 3rd clock, period=4.
   - counter_out changes only on tick cycles.
   - Period spans 12 clocks; pulses are 1 clock wide.
5. Boundaries:
   - period=0: remains IDLE, busy=0.
   - period=1: period_done every tick.
   - gen_enable_in dropped on the wrap cycle: IDLE with a final period_done.
6. Asynchronous reset asserted mid-RUN, between clock edges: all outputs 0 immediately. After release, restarts from counter 0.
